// File: rtl/pipe_stage_reg.sv
// Pipeline-stage register bank: NUM_REG lanes move together as one entry behind
// a valid/ready handshake, with an optional 2-entry skid buffer and a flush squash.
module pipe_stage_reg #(
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_REG        = 4,
  parameter int SKID           = 1,
  parameter int CLEAR_ON_FLUSH = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_flush,
  input  logic                  i_valid,
  output logic                  o_ready,
  input  logic [DATA_WIDTH-1:0] i_data [NUM_REG],
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data [NUM_REG],
  output logic [1:0]            o_count
);

  // Encoding doubles as the occupancy count, so o_count is the state register itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] main_q [NUM_REG];
  logic [DATA_WIDTH-1:0] main_d [NUM_REG];
  logic [DATA_WIDTH-1:0] skid_q [NUM_REG];
  logic [DATA_WIDTH-1:0] skid_d [NUM_REG];
  logic                  in_fire;
  logic                  out_fire;

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high; valid never waits on ready, and an offered entry stays put until taken.
  // A flush cycle drops the upstream offer but still lets the downstream transfer.
  assign o_valid  = (state_q != EMPTY);
  assign o_data   = main_q;
  assign o_count  = state_q;
  assign in_fire  = i_valid & o_ready & ~i_flush;
  assign out_fire = o_valid & i_ready;

  if (SKID != 0) begin : g_skid_ready
    assign o_ready = (state_q != FULL);
  end else begin : g_pass_ready
    assign o_ready = ~o_valid | i_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      for (int i = 0; i < NUM_REG; i++) begin
        main_q[i] <= '0;
        skid_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (i_flush) begin
      state_d = EMPTY;
      if (CLEAR_ON_FLUSH != 0) begin
        for (int i = 0; i < NUM_REG; i++) begin
          main_d[i] = '0;
          skid_d[i] = '0;
        end
      end
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d = ONE;
            main_d  = i_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_d = i_data;
          end else if (in_fire && (SKID != 0)) begin
            state_d = FULL;
            skid_d  = i_data;
          end else if (out_fire) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          // Older skid entry moves up before anything newer is taken.
          if (out_fire) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

`ifndef SYNTHESIS
  logic [DATA_WIDTH*NUM_REG-1:0] o_data_flat;

  always_comb begin
    o_data_flat = '0;
    for (int i = 0; i < NUM_REG; i++) begin
      o_data_flat[i*DATA_WIDTH +: DATA_WIDTH] = main_q[i];
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (o_valid && !i_ready && !i_flush) |=> (o_valid && $stable(o_data_flat)));

  if (SKID == 0) begin : g_no_full_chk
    a_never_full: assert property (@(posedge clk) disable iff (!rst_n)
      o_count != 2'd2);
  end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: three instances (skid/hold, skid/clear,
// no-skid) share one input bus; a vector table plus hand-written corner sequences.
module tb_pipe_stage_reg;

  localparam int DW = 8;
  localparam int NR = 6;

  logic          clk;
  logic          rst_n;
  logic          i_flush;
  logic          i_valid;
  logic          i_ready;
  logic [DW-1:0] din   [NR];
  logic [DW-1:0] dout0 [NR];
  logic [DW-1:0] dout1 [NR];
  logic [DW-1:0] dout2 [NR];
  logic          rdy0, rdy1, rdy2;
  logic          vld0, vld1, vld2;
  logic [1:0]    cnt0, cnt1, cnt2;

  int checks = 0;
  int errors = 0;

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_REG(NR), .SKID(1), .CLEAR_ON_FLUSH(0)) u_skid_hold (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy0),
    .i_data(din), .o_valid(vld0), .i_ready(i_ready), .o_data(dout0), .o_count(cnt0));

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_REG(NR), .SKID(1), .CLEAR_ON_FLUSH(1)) u_skid_clr (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy1),
    .i_data(din), .o_valid(vld1), .i_ready(i_ready), .o_data(dout1), .o_count(cnt1));

  pipe_stage_reg #(.DATA_WIDTH(DW), .NUM_REG(NR), .SKID(0), .CLEAR_ON_FLUSH(0)) u_noskid (
    .clk(clk), .rst_n(rst_n), .i_flush(i_flush), .i_valid(i_valid), .o_ready(rdy2),
    .i_data(din), .o_valid(vld2), .i_ready(i_ready), .o_data(dout2), .o_count(cnt2));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        flush;
    logic        valid;
    logic        ready;
    logic [47:0] data;
    logic        exp_valid;
    logic        exp_ready;
    logic [1:0]  exp_count;
    logic        chk_data;
    logic        clr_zero;
    logic [47:0] exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [47:0] rep(input logic [7:0] b);
    return {6{b}};
  endfunction

  function automatic logic [47:0] pack(input logic [DW-1:0] a [NR]);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < NR; i++) r[8*i +: 8] = a[i];
    return r;
  endfunction

  // Driver tasks
  task automatic set_data(input logic [47:0] d);
    for (int i = 0; i < NR; i++) din[i] = d[8*i +: 8];
  endtask

  task automatic add(input logic fl, input logic v, input logic r, input logic [47:0] d,
                     input logic ev, input logic er, input logic [1:0] ec,
                     input logic cd, input logic cz, input logic [47:0] ed);
    vec_t t;
    t.flush = fl; t.valid = v; t.ready = r; t.data = d;
    t.exp_valid = ev; t.exp_ready = er; t.exp_count = ec;
    t.chk_data = cd; t.clr_zero = cz; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  // Scoreboard compare
  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    i_flush = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b1;
    set_data(48'hFFEEDDCCBBAA);

    // Reset applied with a live upstream offer: nothing may be captured.
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid0", 48'(vld0), 48'd0);
    check("rst_count0", 48'(cnt0), 48'd0);
    check("rst_ready0", 48'(rdy0), 48'd1);
    check("rst_data0",  pack(dout0), 48'd0);
    check("rst_data1",  pack(dout1), 48'd0);
    check("rst_ready2", 48'(rdy2), 48'd1);
    check("rst_valid2", 48'(vld2), 48'd0);

    // Vector table: inputs for one cycle, expected outputs after the next edge.
    add(0, 1, 1, 48'hFFEEDDCCBBAA, 1, 1, 1, 1, 0, 48'hFFEEDDCCBBAA);
    for (int k = 0; k < 8; k++) add(0, 1, 1, rep(8'(k)), 1, 1, 1, 1, 0, rep(8'(k)));
    add(0, 0, 1, '0, 0, 1, 0, 0, 0, '0);
    // Backpressure into the skid buffer, then drain in order.
    add(0, 1, 0, rep(8'h01), 1, 1, 1, 1, 0, rep(8'h01));
    add(0, 1, 0, rep(8'h02), 1, 0, 2, 1, 0, rep(8'h01));
    add(0, 1, 0, rep(8'h03), 1, 0, 2, 1, 0, rep(8'h01));
    add(0, 1, 1, rep(8'h03), 1, 1, 1, 1, 0, rep(8'h02));
    add(0, 1, 1, rep(8'h03), 1, 1, 1, 1, 0, rep(8'h03));
    add(0, 0, 1, '0, 0, 1, 0, 0, 0, '0);
    // Flush while FULL with a competing offer of 55.
    add(0, 1, 0, rep(8'h10), 1, 1, 1, 1, 0, rep(8'h10));
    add(0, 1, 0, rep(8'h11), 1, 0, 2, 1, 0, rep(8'h10));
    add(1, 1, 0, rep(8'h55), 0, 1, 0, 1, 1, rep(8'h10));
    add(0, 0, 1, rep(8'h55), 0, 1, 0, 1, 1, rep(8'h10));
    add(0, 1, 1, rep(8'h66), 1, 1, 1, 1, 0, rep(8'h66));
    // Flush in ONE while downstream accepts; the 67 offer is dropped.
    add(1, 1, 1, rep(8'h67), 0, 1, 0, 1, 1, rep(8'h66));
    add(0, 0, 1, '0, 0, 1, 0, 1, 1, rep(8'h66));

    @(negedge clk);
    rst_n = 1'b1;
    foreach (vecs[i]) begin
      i_flush = vecs[i].flush;
      i_valid = vecs[i].valid;
      i_ready = vecs[i].ready;
      set_data(vecs[i].data);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_valid0", i), 48'(vld0), 48'(vecs[i].exp_valid));
      check($sformatf("v%0d_ready0", i), 48'(rdy0), 48'(vecs[i].exp_ready));
      check($sformatf("v%0d_count0", i), 48'(cnt0), 48'(vecs[i].exp_count));
      check($sformatf("v%0d_valid1", i), 48'(vld1), 48'(vecs[i].exp_valid));
      check($sformatf("v%0d_count1", i), 48'(cnt1), 48'(vecs[i].exp_count));
      if (vecs[i].chk_data) begin
        check($sformatf("v%0d_data0", i), pack(dout0), vecs[i].exp_data);
        check($sformatf("v%0d_data1", i), pack(dout1),
              vecs[i].clr_zero ? 48'd0 : vecs[i].exp_data);
      end
      @(negedge clk);
    end

    // No-skid instance: ready follows downstream ready within the same cycle.
    i_flush = 1'b0;
    i_valid = 1'b1;
    i_ready = 1'b0;
    set_data(rep(8'h30));
    #1;
    check("ns_ready_empty", 48'(rdy2), 48'd1);
    @(posedge clk);
    #1;
    check("ns_valid_a", 48'(vld2), 48'd1);
    check("ns_data_a",  pack(dout2), rep(8'h30));
    check("ns_count_a", 48'(cnt2), 48'd1);
    check("ns_ready_blocked", 48'(rdy2), 48'd0);
    @(negedge clk);
    set_data(rep(8'h31));
    #1;
    check("ns_ready_b", 48'(rdy2), 48'd0);
    @(posedge clk);
    #1;
    check("ns_data_held", pack(dout2), rep(8'h30));
    check("ns_count_b",   48'(cnt2), 48'd1);
    @(negedge clk);
    i_ready = 1'b1;
    #1;
    check("ns_ready_comb", 48'(rdy2), 48'd1);
    @(posedge clk);
    #1;
    check("ns_data_replaced", pack(dout2), rep(8'h31));
    check("ns_valid_c", 48'(vld2), 48'd1);
    check("ns_count_c", 48'(cnt2), 48'd1);
    @(negedge clk);
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ns_valid_d", 48'(vld2), 48'd0);
    check("ns_count_d", 48'(cnt2), 48'd0);
    @(negedge clk);

    // Asynchronous reset while FULL, asserted between edges.
    i_valid = 1'b1;
    i_ready = 1'b0;
    set_data(rep(8'h40));
    @(posedge clk);
    @(negedge clk);
    set_data(rep(8'h41));
    @(posedge clk);
    #1;
    check("ar_count_full", 48'(cnt0), 48'd2);
    check("ar_ready_full", 48'(rdy0), 48'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_valid0", 48'(vld0), 48'd0);
    check("ar_count0", 48'(cnt0), 48'd0);
    check("ar_ready0", 48'(rdy0), 48'd1);
    check("ar_data0",  pack(dout0), 48'd0);
    check("ar_data1",  pack(dout1), 48'd0);
    check("ar_count1", 48'(cnt1), 48'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b1;
    i_valid = 1'b0;
    @(posedge clk);
    #1;
    check("ar_post_valid0", 48'(vld0), 48'd0);
    check("ar_post_count0", 48'(cnt0), 48'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised pipeline-stage register bank; successor to the plain enable-loaded register array.
- Carries NUM_REG lanes of DATA_WIDTH bits between processor pipeline stages.
- Uses a valid/ready handshake on both sides, an optional 2-entry skid buffer for full throughput with registered ready, and a flush input to squash in-flight entries on branch/exception.

Parameters:
- DATA_WIDTH, 32, bits per lane.
- NUM_REG, 4, number of lanes moved together as one entry.
- SKID, 1, 1 = 2-entry skid buffer with registered o_ready; 0 = single entry with combinational o_ready.
- CLEAR_ON_FLUSH, 0, 1 = flush also zeroes the stored data; 0 = flush clears only valid bits.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_flush  input  1  squash all held entries.
- i_valid  input  1  upstream entry valid.
- o_ready  output  1  stage can accept an entry.
- i_data  input  DATA_WIDTH x NUM_REG  upstream lanes (unpacked array [NUM_REG]).
- o_valid  output  1  downstream entry valid.
- i_ready  input  1  downstream accepts.
- o_data  output  DATA_WIDTH x NUM_REG  downstream lanes (unpacked array [NUM_REG]).
- o_count  output  2  occupancy, 0..2.

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset (rst_n=0, immediate, no clock needed):
  - main and skid valid = 0; all data lanes = 0; o_count = 0.
  - o_ready reads 1 during and after reset in both modes (state EMPTY).
- Fire conditions: in_fire = i_valid & o_ready & !i_flush; out_fire = o_valid & i_ready.
- Outputs:
  - o_data always shows the main register. o_valid = main valid.
  - The skid entry is never visible at the output.
- States: EMPTY (no valid), ONE (main valid), FULL (main + skid valid; SKID=1 only). o_count = 0/1/2 respectively.
- SKID=1:
  - o_ready = !skid_valid, a registered function of state only; it does not depend on i_ready.
  - EMPTY: in_fire -> ONE, main<=i_data.
  - ONE: in_fire & out_fire -> ONE, main<=i_data. in_fire & !out_fire -> FULL, skid<=i_data. out_fire only -> EMPTY.
  - FULL: o_ready=0. out_fire -> ONE, main<=skid. Otherwise hold.
- SKID=0:
  - o_ready = !o_valid | i_ready (combinational).
  - EMPTY/ONE only, same transitions as above; FULL is unreachable.
- Latency and throughput: an entry accepted at edge N is visible on o_data/o_valid after edge N; minimum latency 1 cycle. Sustained throughput is 1 entry/cycle in both modes.
- Ordering: strict FIFO; the skid entry always drains before any newer entry.
- Flush:
  - Highest priority. At the next edge all valid bits clear and the state becomes EMPTY.
  - An i_valid in the flush cycle is dropped (in_fire forced 0).
  - out_fire may still occur in the flush cycle; downstream sees it as accepted, and the stage owner must gate that with flush.
  - CLEAR_ON_FLUSH=1: main and skid data zeroed. CLEAR_ON_FLUSH=0: data held and stale, valid=0.
- Hold: with no fire, all registers hold. Data in invalid slots is don't-care, except after reset or a CLEAR_ON_FLUSH flush, where it is 0.
- Reset mid-operation: asserting rst_n low in any state forces the reset values immediately; pending entries are lost.
- Lanes: all NUM_REG lanes load together; there is no per-lane enable.
- Assertions:
  - o_valid and o_data stable while o_valid & !i_ready & !i_flush.
  - o_count never 2 when SKID=0.

Test Plan (DATA_WIDTH=8, NUM_REG=6):
1. Reset: rst_n=0 with i_valid=1 and i_data=AA..FF -> o_valid=0, o_data all 00, o_count=0, o_ready=1; rst_n=1 with i_ready=1 -> AA BB CC DD EE FF visible 1 cycle after accept.
2. Streaming, SKID=1: 8 back-to-back entries of value k in all lanes, i_ready=1 -> o_data 0..7 on consecutive cycles, no bubbles, o_count=1 throughout.
3. Backpressure, SKID=1: i_ready=0 while sending 01, 02, 03 -> 01 and 02 accepted, o_count=2, o_ready=0, 03 held upstream; then i_ready=1 -> outputs 01, 02, 03 in order, o_count returns to 1 then 0.
4. Flush in FULL with i_valid=1 (data 55) -> next cycle o_valid=0, o_count=0, o_ready=1, 55 never appears; with CLEAR_ON_FLUSH=1, o_data reads all 00.
5. SKID=0: i_ready=0 with o_valid=1 -> o_ready=0 in the same cycle; raising i_ready -> o_ready=1 in the same cycle, and the new entry replaces the old at the edge.
6. Async reset mid-FULL: drop rst_n between clock edges -> o_valid=0, o_count=0, data 00 before the next edge.
